// File: rtl/seg_entry_pkg.sv
// Shared types and constants for the two-digit answer-entry block.
package seg_entry_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EDIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Key indices into the per-key press/level vectors
    localparam int unsigned UP       = 0;
    localparam int unsigned SEL      = 1;
    localparam int unsigned ENT      = 2;
    localparam int unsigned NUM_KEYS = 3;

    // One BCD step with 9 -> 0 wrap
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/seg_digit_entry_if.sv
// Bundle between the board/controller side and the answer-entry block.
// master: drives enable and raw keys, observes digits/answer.
// slave : the entry block itself.
interface seg_digit_entry_if;

    logic       EN;
    logic       nKEY_UP;
    logic       nKEY_SEL;
    logic       nKEY_ENT;
    logic [3:0] DIG0;
    logic [3:0] DIG1;
    logic       CUR;
    logic [6:0] ANS;
    logic       ANS_VALID;
    logic       BUSY;

    modport master (
        output EN, nKEY_UP, nKEY_SEL, nKEY_ENT,
        input  DIG0, DIG1, CUR, ANS, ANS_VALID, BUSY
    );

    modport slave (
        input  EN, nKEY_UP, nKEY_SEL, nKEY_ENT,
        output DIG0, DIG1, CUR, ANS, ANS_VALID, BUSY
    );

endinterface

// File: rtl/key_debounce.sv
// Raw active-low key -> 2-FF synchronizer -> debouncer -> press (1->0) detector.
// LEVEL is the debounced level (1 = released); PRESS is a one-cycle event.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic nRST,
    input  logic nKEY,
    output logic PRESS,
    output logic LEVEL
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous key into the clock domain (released = 1 at reset)
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= nKEY;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive mismatching cycles
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            level <= 1'b1;
            cnt   <= '0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            level <= sync2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Previous debounced level for edge detection
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            level_d <= 1'b1;
        end else begin
            level_d <= level;
        end
    end

    assign PRESS = level_d & ~level;
    assign LEVEL = level;

endmodule

// File: rtl/seg_digit_entry.sv
// Two-digit BCD answer entry: UP increments the selected digit, SEL toggles
// the selection, ENT commits DIG1*10+DIG0 with a one-cycle valid strobe.
// Optional build macro AUTO_REPEAT_EN: a held UP key re-fires every
// REPEAT_CYCLES while editing.
module seg_digit_entry
    import seg_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input logic              CLK,
    input logic              nRST,
    seg_digit_entry_if.slave bus
);

    state_t                state;
    state_t                next_state;
    logic [NUM_KEYS-1:0]   nkey;
    logic [NUM_KEYS-1:0]   press;
    logic [NUM_KEYS-1:0]   level;
    logic                  up_evt;
    logic                  do_commit;
    logic                  do_toggle;
    logic                  do_inc;
    logic [3:0]            dig0;
    logic [3:0]            dig1;
    logic                  cur;
    logic [6:0]            ans;
    logic                  ans_valid;

    assign nkey[UP]  = bus.nKEY_UP;
    assign nkey[SEL] = bus.nKEY_SEL;
    assign nkey[ENT] = bus.nKEY_ENT;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
        .CLK(CLK), .nRST(nRST), .nKEY(nkey[UP]),  .PRESS(press[UP]),  .LEVEL(level[UP])
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_sel (
        .CLK(CLK), .nRST(nRST), .nKEY(nkey[SEL]), .PRESS(press[SEL]), .LEVEL(level[SEL])
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_ent (
        .CLK(CLK), .nRST(nRST), .nKEY(nkey[ENT]), .PRESS(press[ENT]), .LEVEL(level[ENT])
    );

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_fire;
    logic             unused_levels;

    assign rpt_fire = (state == EDIT) && !level[UP] && (rpt_cnt == RPT_MAX);

    // Time how long UP has been held while editing; restart on every repeat
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rpt_cnt <= '0;
        end else if (state != EDIT || level[UP] || rpt_fire) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end

    assign up_evt        = press[UP] | rpt_fire;
    assign unused_levels = level[SEL] ^ level[ENT];
`else
    logic unused_levels;

    assign up_evt = press[UP];
    // Debounced levels and the repeat period only matter to auto-repeat
    assign unused_levels = ^{level, 32'(REPEAT_CYCLES)};
`endif

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and edit actions; ENT > SEL > UP, losers are dropped
    always_comb begin
        next_state = state;
        do_commit  = 1'b0;
        do_toggle  = 1'b0;
        do_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.EN) next_state = EDIT;
            end
            EDIT: begin
                if (!bus.EN) begin
                    next_state = IDLE;
                end else if (press[ENT]) begin
                    do_commit  = 1'b1;
                    next_state = DONE;
                end else if (press[SEL]) begin
                    do_toggle = 1'b1;
                end else if (up_evt) begin
                    do_inc = 1'b1;
                end
            end
            DONE: begin
                if (!bus.EN) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Digit and selection registers; cleared whenever heading to IDLE
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dig0 <= '0;
            dig1 <= '0;
            cur  <= 1'b0;
        end else if (next_state == IDLE) begin
            dig0 <= '0;
            dig1 <= '0;
            cur  <= 1'b0;
        end else if (do_toggle) begin
            cur <= ~cur;
        end else if (do_inc) begin
            if (cur) dig1 <= bcd_inc(dig1);
            else     dig0 <= bcd_inc(dig0);
        end
    end

    // Committed answer and its one-cycle strobe
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ans       <= '0;
            ans_valid <= 1'b0;
        end else begin
            ans_valid <= do_commit;
            if (do_commit) ans <= {3'b000, dig1} * 7'd10 + {3'b000, dig0};
        end
    end

    assign bus.DIG0      = dig0;
    assign bus.DIG1      = dig1;
    assign bus.CUR       = cur;
    assign bus.ANS       = ans;
    assign bus.ANS_VALID = ans_valid;
    assign bus.BUSY      = (state == EDIT);

endmodule

// File: doc/seg_digit_entry.md
# seg_digit_entry

Player answer-entry encoder for the factorization game. It turns three raw push-buttons into a two-digit BCD answer, feeds the two digits to the 7-segment decoders, and emits the committed binary answer with a one-cycle valid strobe. It sits between the board KEY inputs and the game controller, and is active only while the controller holds it enabled (the INPUT phase).

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a key level is accepted (10 ms at 50 MHz).
- REPEAT_CYCLES, 12500000: auto-repeat period for a held UP key. Used only with AUTO_REPEAT_EN.
- CLK  in  1  system clock; all logic on the rising edge.
- nRST  in  1  reset, asynchronous assert, active-low.
- EN  in  1  entry enable from the game controller; high = INPUT phase.
- nKEY_UP  in  1  raw button, active-low, asynchronous: increment the selected digit.
- nKEY_SEL  in  1  raw button, active-low, asynchronous: toggle the selected digit.
- nKEY_ENT  in  1  raw button, active-low, asynchronous: commit the answer.
- DIG0  out  4  units digit, BCD 0–9, to the decoder DIN.
- DIG1  out  4  tens digit, BCD 0–9, to the decoder DIN.
- CUR  out  1  selected digit: 0 = DIG0, 1 = DIG1.
- ANS  out  7  committed answer, binary 0–99.
- ANS_VALID  out  1  one-cycle pulse when ANS is updated.
- BUSY  out  1  high in EDIT.

## Operation
- Each key input passes through:
  - a 2-FF synchronizer;
  - a debouncer that updates its debounced level only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles;
  - a press detector that fires a one-cycle event on the debounced 1→0 transition.
- Releases generate no event.
- The FSM has three states: IDLE, EDIT, DONE.
- IDLE:
  - DIG0 = DIG1 = 0, CUR = 0.
  - EN = 1 moves to EDIT on the next cycle.
  - Key events are ignored.
- EDIT:
  - UP event: the selected digit becomes digit+1, wrapping 9→0. The other digit is unchanged.
  - SEL event: CUR toggles.
  - ENT event:
    - ANS = DIG1×10 + DIG0.
    - ANS_VALID = 1 for exactly one cycle.
    - Move to DONE.
  - Simultaneous events in one cycle follow the priority ENT > SEL > UP. Lower-priority events are dropped, not queued.
- DONE:
  - Digits and ANS are held for display.
  - Key events are ignored.
  - EN = 0 moves to IDLE.
- EN = 0 in any state moves to IDLE on the next cycle and clears the digits and CUR. ANS holds its last value.
- An illegal state encoding recovers to IDLE.
- ANS is computed with a 7-bit result. The maximum is 99, so there is no overflow.

## Timing
- Reset values:
  - FSM = IDLE.
  - DIG0 = DIG1 = 0, CUR = 0, ANS = 0, ANS_VALID = 0, BUSY = 0.
  - Debounced levels = 1 (released); debounce counters = 0.
- Key latency: a raw press that is stable from cycle t produces its event at cycle t+2+DEBOUNCE_CYCLES. DIG/CUR update one cycle later.
- Bounces shorter than DEBOUNCE_CYCLES never produce an event; any mismatch-free cycle resets the counter.
- ANS and ANS_VALID are registered. Both assert in the cycle after the ENT event. ANS_VALID deasserts the following cycle.
- EN rise to BUSY = 1: 1 cycle. EN fall to BUSY = 0 and digits cleared: 1 cycle.
- A key held across an EN rise generates no event until it is released and pressed again.
- Reset mid-operation returns all state to the reset values immediately, with no ANS_VALID.

## Configuration
- The macro is AUTO_REPEAT_EN.
- Defined:
  - After the UP debounced level has been low for REPEAT_CYCLES, an additional UP event fires.
  - Further events fire every REPEAT_CYCLES while the key is held in EDIT.
  - The repeat counter resets on release and on leaving EDIT.
  - Priority rules apply unchanged.
- Undefined: one UP event per press only. The repeat counter and REPEAT_CYCLES logic are absent.

## Structure
- Package seg_entry_pkg holds:
  - the FSM state enum (IDLE, EDIT, DONE);
  - the BCD_MAX = 9 constant;
  - the key index constants UP/SEL/ENT.
- Sub-module key_debounce (synchronizer + debouncer + press detector) has parameter DEBOUNCE_CYCLES and ports CLK, nRST, nKEY, PRESS, LEVEL. It is instantiated three times.
- The top level contains the FSM, the digit registers, the answer computation, and the optional auto-repeat.

## Test plan
Run all scenarios with DEBOUNCE_CYCLES = 4 and REPEAT_CYCLES = 16.
- Reset, EN = 1, press UP 3 times, SEL, UP 4 times, ENT → DIG1 = 4, DIG0 = 3, ANS = 43, ANS_VALID high exactly one cycle, BUSY = 0 after.
- In EDIT press UP 10 times with CUR = 0 → DIG0 sequence 1…9, 0; DIG1 unchanged at 0.
- Glitch nKEY_UP low for 3 cycles, then 5 stable cycles → exactly one event, at cycle 2+4 after the stable edge.
- Assert UP, SEL and ENT events in the same cycle → commit only: ANS = current value, CUR and digits unchanged.
- EN drops mid-EDIT with digits 7,2, then reasserts → digits 0,0, CUR = 0, no ANS_VALID, ANS retains its prior value. Repeat with nRST asserted mid-EDIT → all outputs at reset values.
- AUTO_REPEAT_EN defined: hold UP 50 cycles after debounce → 1 + 3 increments. Undefined: exactly 1.
